mod_n_counter: RTL and testbench
================================

# mod_n_counter

Parametrised modulo-N up/down counter, the general successor to the fixed mod-8 counter. It adds configurable width and modulus, direction control, count enable, and synchronous parallel load with clamping. It also provides a one-shot stop mode, a cascadable terminal-count output, a sticky wrap flag and a registered Gray-coded copy of the count. It is used wherever the design needs a programmable sequencer, divider or event counter.

## Interface

- WIDTH, 4, counter width in bits; legal range 2..16
- MODULUS, 10, count period; legal range 2..2^WIDTH; count runs 0..MODULUS-1

- clk  input  1  rising-edge clock, the only clock
- rst  input  1  asynchronous reset, active-low
- en  input  1  count enable, sampled on rising clk
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous parallel load
- load_val  input  WIDTH  value to load
- oneshot  input  1  1 = stop at terminal value instead of wrapping
- clr_sticky  input  1  synchronous clear of wrapped
- out  output  WIDTH  registered count value
- gray  output  WIDTH  registered Gray code of out, so gray = out ^ (out >> 1)
- tc  output  1  combinational terminal-count strobe, for cascading
- wrapped  output  1  registered sticky flag, set on every wrap
- done  output  1  registered flag, high when a one-shot count has stopped

## Operation

- Reset (rst = 0): out, gray, wrapped and done go to 0 immediately, independent of clk. All inputs are ignored while rst = 0.
- Terminal value: MODULUS-1 when up = 1; 0 when up = 0.
- Priority at each rising edge, highest first: load, then count, then hold.
- Load:
  - If load_val is MODULUS or greater, out is set to MODULUS-1 (clamped). Otherwise out is set to load_val.
  - Load clears done and does not touch wrapped.
  - en is ignored on that edge.
- Count: applies when en = 1, load = 0 and done = 0.
  - Up: out increments. At MODULUS-1, out wraps to 0 and wrapped is set.
  - Down: out decrements. At 0, out wraps to MODULUS-1 and wrapped is set.
  - Arithmetic is performed at WIDTH+1 bits and never overflows WIDTH. MODULUS = 2^WIDTH must behave identically to natural rollover.
- One-shot (oneshot = 1): a count edge taken while out is at the terminal value sets done = 1 and out holds. There is no wrap and wrapped is not set.
- While done = 1, en has no effect. done clears only on load or reset. Dropping oneshot while done = 1 does not clear done.
- Hold: applies when en = 0 or done = 1 (and load = 0). All registers keep their values.
- tc = en & ~done & ~load & (out == terminal value). It is a pure function of current inputs and state. The next stage counts when its en is driven by this stage's tc.
- wrapped:
  - Set on any wrap edge.
  - Cleared by clr_sticky = 1 on an edge with no wrap.
  - If a wrap and clr_sticky occur on the same edge, the set wins and wrapped = 1.
- Changing up mid-count takes effect on the next enabled edge. The terminal value and tc follow up combinationally.
- gray is updated on the same edge as out, so both always describe the same count.

## Timing

- All state changes occur on the rising edge of clk, except asynchronous reset assertion.
- Load and count latency: 1 cycle from the sampling edge to the new out/gray.
- tc has zero latency, valid in the same cycle as its inputs. Use it only as a synchronous enable downstream.
- wrapped and done are valid in the cycle after the edge that caused them.
- rst deassertion must meet recovery time to clk. The first count edge is the first rising clk after release.
- Bench clock: 20-unit period (toggle every 10). Stimulus changes on the falling edge.

## Test plan

- Reset mid-count: count up to 6, pull rst low between edges -> out = 0, gray = 0, wrapped = 0, done = 0 immediately. After release, en = 1 gives out = 1 on the first rising edge.
- Up wrap (WIDTH = 4, MODULUS = 10): en = 1, up = 1 from 0 -> sequence 0..9,0. tc = 1 only while out = 9. wrapped rises on the 9->0 edge. gray reads 0000,0001,0011,0010,... matching out.
- Down wrap: load 0, then up = 0, en = 1 -> out goes 0, 9, 8. wrapped set on the 0->9 edge. tc = 1 while out = 0.
- Load clamp and priority: load = 1, load_val = 13, en = 1 -> out = 9, not 10 or 0. Then load_val = 4 -> out = 4. done is cleared.
- One-shot: oneshot = 1, up = 1, from 7 -> 8, 9, then holds at 9 with done = 1 and wrapped = 0. tc = 0 while done = 1. Load 2 -> done = 0 and counting resumes.
- Sticky race and cascade: assert clr_sticky on the same edge as the 9->0 wrap -> wrapped = 1. clr_sticky on the next edge -> wrapped = 0. Two instances with stage 1's en driven by stage 0's tc -> stage 1 advances exactly once per 10 stage-0 counts.

Source files
------------

// File: rtl/mod_n_counter_if.sv
// Control/status bundle for mod_n_counter: the driver uses master, the counter uses slave.
interface mod_n_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             oneshot;
  logic             clr_sticky;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] gray;
  logic             tc;
  logic             wrapped;
  logic             done;

  modport master (
    output en, up, load, load_val, oneshot, clr_sticky,
    input  out, gray, tc, wrapped, done
  );

  modport slave (
    input  en, up, load, load_val, oneshot, clr_sticky,
    output out, gray, tc, wrapped, done
  );
endinterface

// File: rtl/mod_n_counter.sv
// Modulo-N up/down counter with clamped load, one-shot stop, cascadable tc,
// sticky wrap flag and a registered Gray copy of the count.
module mod_n_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic            clk,
  input  logic            rst,
  mod_n_counter_if.slave  bus
);
  // Working at WIDTH+1 bits keeps MODULUS = 2^WIDTH representable.
  localparam logic [WIDTH:0] MOD_X  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] ONE_X  = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] LAST_X = MOD_X - ONE_X;

  logic [WIDTH:0]   out_x;
  logic [WIDTH:0]   term_x;
  logic             at_term;
  logic             count_edge;
  logic             wrap_evt;
  logic             stop_evt;
  logic [WIDTH-1:0] next_out;

  assign out_x      = {1'b0, bus.out};
  assign term_x     = bus.up ? LAST_X : '0;
  assign at_term    = (out_x == term_x);
  assign count_edge = bus.en & ~bus.done & ~bus.load;
  assign bus.tc     = count_edge & at_term;
  assign stop_evt   = bus.tc & bus.oneshot;
  assign wrap_evt   = bus.tc & ~bus.oneshot;

  always_comb begin
    next_out = bus.out;
    if (bus.load) begin
      if ({1'b0, bus.load_val} >= MOD_X) next_out = WIDTH'(LAST_X);
      else                               next_out = bus.load_val;
    end else if (count_edge) begin
      if (at_term) begin
        if (!bus.oneshot) next_out = bus.up ? '0 : WIDTH'(LAST_X);
      end else begin
        next_out = bus.up ? WIDTH'(out_x + ONE_X) : WIDTH'(out_x - ONE_X);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.out     <= '0;
      bus.gray    <= '0;
      bus.wrapped <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      bus.out  <= next_out;
      bus.gray <= next_out ^ (next_out >> 1);
      if (bus.load)     bus.done <= 1'b0;
      else if (stop_evt) bus.done <= 1'b1;
      // A wrap on the same edge as clr_sticky must leave the flag set.
      if (wrap_evt)            bus.wrapped <= 1'b1;
      else if (bus.clr_sticky) bus.wrapped <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mod_n_counter.sv
// Directed bench for mod_n_counter: two cascaded stages, WIDTH=4, MODULUS=10.
module tb_mod_n_counter;
  localparam int WIDTH   = 4;
  localparam int MODULUS = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  mod_n_counter_if #(.WIDTH(WIDTH)) bus0 ();
  mod_n_counter_if #(.WIDTH(WIDTH)) bus1 ();

  assign bus1.en = bus0.tc;

  mod_n_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u0 (.clk(clk), .rst(rst), .bus(bus0));
  mod_n_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u1 (.clk(clk), .rst(rst), .bus(bus1));

  always #10 clk = ~clk;

  function automatic logic [3:0] g(input logic [3:0] v);
    return v ^ (v >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #5;
    checks++; if (bus0.out !== 4'd0) begin failures++; $display("FAIL reset_out got=%0d exp=0", bus0.out); end
    checks++; if (bus0.gray !== 4'd0) begin failures++; $display("FAIL reset_gray got=%0d exp=0", bus0.gray); end
    checks++; if (bus0.wrapped !== 1'b0) begin failures++; $display("FAIL reset_wrapped got=%b exp=0", bus0.wrapped); end
    checks++; if (bus0.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus0.done); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_up_wrap();
    logic [3:0] e;
    bus0.en = 1'b1;
    bus0.up = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      e = 4'(i % 10);
      #1;
      checks++; if (bus0.out !== e) begin failures++; $display("FAIL up_out step=%0d got=%0d exp=%0d", i, bus0.out, e); end
      checks++; if (bus0.gray !== g(e)) begin failures++; $display("FAIL up_gray step=%0d got=%b exp=%b", i, bus0.gray, g(e)); end
      checks++; if (bus0.tc !== (i == 9)) begin failures++; $display("FAIL up_tc step=%0d got=%b exp=%b", i, bus0.tc, (i == 9)); end
      checks++; if (bus0.wrapped !== (i == 10)) begin failures++; $display("FAIL up_wrapped step=%0d got=%b exp=%b", i, bus0.wrapped, (i == 10)); end
      if (i < 10) tick();
    end
  endtask

  task automatic test_reset_midcount();
    for (int i = 0; i < 6; i++) tick();
    #1;
    checks++; if (bus0.out !== 4'd6) begin failures++; $display("FAIL mid_pre_out got=%0d exp=6", bus0.out); end
    rst = 1'b0;
    #1;
    checks++; if (bus0.out !== 4'd0) begin failures++; $display("FAIL mid_rst_out got=%0d exp=0", bus0.out); end
    checks++; if (bus0.gray !== 4'd0) begin failures++; $display("FAIL mid_rst_gray got=%0d exp=0", bus0.gray); end
    checks++; if (bus0.wrapped !== 1'b0) begin failures++; $display("FAIL mid_rst_wrapped got=%b exp=0", bus0.wrapped); end
    checks++; if (bus0.done !== 1'b0) begin failures++; $display("FAIL mid_rst_done got=%b exp=0", bus0.done); end
    tick();
    #1;
    checks++; if (bus0.out !== 4'd0) begin failures++; $display("FAIL mid_hold_out got=%0d exp=0", bus0.out); end
    rst = 1'b1;
    tick();
    #1;
    checks++; if (bus0.out !== 4'd1) begin failures++; $display("FAIL mid_first_out got=%0d exp=1", bus0.out); end
  endtask

  task automatic test_down_wrap();
    bus0.load = 1'b1; bus0.load_val = 4'd0; bus0.en = 1'b0;
    tick();
    bus0.load = 1'b0; bus0.up = 1'b0; bus0.en = 1'b1;
    #1;
    checks++; if (bus0.out !== 4'd0) begin failures++; $display("FAIL down_out0 got=%0d exp=0", bus0.out); end
    checks++; if (bus0.tc !== 1'b1) begin failures++; $display("FAIL down_tc0 got=%b exp=1", bus0.tc); end
    checks++; if (bus0.wrapped !== 1'b0) begin failures++; $display("FAIL down_wrapped0 got=%b exp=0", bus0.wrapped); end
    tick(); #1;
    checks++; if (bus0.out !== 4'd9) begin failures++; $display("FAIL down_out9 got=%0d exp=9", bus0.out); end
    checks++; if (bus0.gray !== 4'd13) begin failures++; $display("FAIL down_gray9 got=%0d exp=13", bus0.gray); end
    checks++; if (bus0.wrapped !== 1'b1) begin failures++; $display("FAIL down_wrapped9 got=%b exp=1", bus0.wrapped); end
    checks++; if (bus0.tc !== 1'b0) begin failures++; $display("FAIL down_tc9 got=%b exp=0", bus0.tc); end
    tick(); #1;
    checks++; if (bus0.out !== 4'd8) begin failures++; $display("FAIL down_out8 got=%0d exp=8", bus0.out); end
    checks++; if (bus0.gray !== 4'd12) begin failures++; $display("FAIL down_gray8 got=%0d exp=12", bus0.gray); end
  endtask

  task automatic test_load_clamp();
    bus0.load = 1'b1; bus0.load_val = 4'd13; bus0.en = 1'b1; bus0.up = 1'b1;
    tick(); #1;
    checks++; if (bus0.out !== 4'd9) begin failures++; $display("FAIL clamp_out got=%0d exp=9", bus0.out); end
    checks++; if (bus0.gray !== 4'd13) begin failures++; $display("FAIL clamp_gray got=%0d exp=13", bus0.gray); end
    checks++; if (bus0.tc !== 1'b0) begin failures++; $display("FAIL clamp_tc_load got=%b exp=0", bus0.tc); end
    bus0.load_val = 4'd4;
    tick(); #1;
    checks++; if (bus0.out !== 4'd4) begin failures++; $display("FAIL load4_out got=%0d exp=4", bus0.out); end
    checks++; if (bus0.gray !== 4'd6) begin failures++; $display("FAIL load4_gray got=%0d exp=6", bus0.gray); end
    checks++; if (bus0.done !== 1'b0) begin failures++; $display("FAIL load4_done got=%b exp=0", bus0.done); end
    checks++; if (bus0.wrapped !== 1'b1) begin failures++; $display("FAIL load4_wrapped got=%b exp=1", bus0.wrapped); end
    bus0.load = 1'b0;
  endtask

  task automatic test_oneshot();
    bus0.load = 1'b1; bus0.load_val = 4'd7; bus0.en = 1'b0; bus0.clr_sticky = 1'b1;
    tick();
    bus0.load = 1'b0; bus0.clr_sticky = 1'b0; bus0.en = 1'b1; bus0.up = 1'b1; bus0.oneshot = 1'b1;
    #1;
    checks++; if (bus0.out !== 4'd7) begin failures++; $display("FAIL os_out7 got=%0d exp=7", bus0.out); end
    checks++; if (bus0.wrapped !== 1'b0) begin failures++; $display("FAIL os_clr_wrapped got=%b exp=0", bus0.wrapped); end
    tick(); #1;
    checks++; if (bus0.out !== 4'd8) begin failures++; $display("FAIL os_out8 got=%0d exp=8", bus0.out); end
    tick(); #1;
    checks++; if (bus0.out !== 4'd9) begin failures++; $display("FAIL os_out9 got=%0d exp=9", bus0.out); end
    checks++; if (bus0.tc !== 1'b1) begin failures++; $display("FAIL os_tc9 got=%b exp=1", bus0.tc); end
    checks++; if (bus0.done !== 1'b0) begin failures++; $display("FAIL os_done_pre got=%b exp=0", bus0.done); end
    tick(); #1;
    checks++; if (bus0.out !== 4'd9) begin failures++; $display("FAIL os_hold_out got=%0d exp=9", bus0.out); end
    checks++; if (bus0.done !== 1'b1) begin failures++; $display("FAIL os_done got=%b exp=1", bus0.done); end
    checks++; if (bus0.wrapped !== 1'b0) begin failures++; $display("FAIL os_wrapped got=%b exp=0", bus0.wrapped); end
    checks++; if (bus0.tc !== 1'b0) begin failures++; $display("FAIL os_tc_done got=%b exp=0", bus0.tc); end
    bus0.oneshot = 1'b0;
    tick(); #1;
    checks++; if (bus0.out !== 4'd9) begin failures++; $display("FAIL os_drop_out got=%0d exp=9", bus0.out); end
    checks++; if (bus0.done !== 1'b1) begin failures++; $display("FAIL os_drop_done got=%b exp=1", bus0.done); end
    bus0.load = 1'b1; bus0.load_val = 4'd2;
    tick();
    bus0.load = 1'b0;
    #1;
    checks++; if (bus0.out !== 4'd2) begin failures++; $display("FAIL os_reload_out got=%0d exp=2", bus0.out); end
    checks++; if (bus0.done !== 1'b0) begin failures++; $display("FAIL os_reload_done got=%b exp=0", bus0.done); end
    tick(); #1;
    checks++; if (bus0.out !== 4'd3) begin failures++; $display("FAIL os_resume_out got=%0d exp=3", bus0.out); end
  endtask

  task automatic test_sticky_race();
    bus0.load = 1'b1; bus0.load_val = 4'd8;
    tick();
    bus0.load = 1'b0;
    tick();
    bus0.clr_sticky = 1'b1;
    #1;
    checks++; if (bus0.out !== 4'd9) begin failures++; $display("FAIL race_pre_out got=%0d exp=9", bus0.out); end
    checks++; if (bus0.wrapped !== 1'b0) begin failures++; $display("FAIL race_pre_wrapped got=%b exp=0", bus0.wrapped); end
    tick(); #1;
    checks++; if (bus0.out !== 4'd0) begin failures++; $display("FAIL race_out got=%0d exp=0", bus0.out); end
    checks++; if (bus0.wrapped !== 1'b1) begin failures++; $display("FAIL race_wrapped got=%b exp=1", bus0.wrapped); end
    bus0.en = 1'b0;
    tick(); #1;
    checks++; if (bus0.wrapped !== 1'b0) begin failures++; $display("FAIL race_clear got=%b exp=0", bus0.wrapped); end
    bus0.clr_sticky = 1'b0;
  endtask

  task automatic test_cascade();
    bus0.load = 1'b1; bus0.load_val = 4'd0; bus0.en = 1'b0;
    bus1.load = 1'b1; bus1.load_val = 4'd0;
    tick();
    bus0.load = 1'b0; bus1.load = 1'b0; bus0.en = 1'b1; bus0.up = 1'b1;
    for (int k = 0; k <= 30; k++) begin
      #1;
      checks++; if (bus0.out !== 4'(k % 10)) begin failures++; $display("FAIL casc_s0 k=%0d got=%0d exp=%0d", k, bus0.out, k % 10); end
      checks++; if (bus1.out !== 4'(k / 10)) begin failures++; $display("FAIL casc_s1 k=%0d got=%0d exp=%0d", k, bus1.out, k / 10); end
      if (k < 30) tick();
    end
    bus0.en = 1'b0;
  endtask

  initial begin
    bus0.en = 1'b0; bus0.up = 1'b1; bus0.load = 1'b0; bus0.load_val = '0;
    bus0.oneshot = 1'b0; bus0.clr_sticky = 1'b0;
    bus1.up = 1'b1; bus1.load = 1'b0; bus1.load_val = '0;
    bus1.oneshot = 1'b0; bus1.clr_sticky = 1'b0;
    test_reset();
    test_up_wrap();
    test_reset_midcount();
    test_down_wrap();
    test_load_clamp();
    test_oneshot();
    test_sticky_race();
    test_cascade();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
